// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that drives an external 4-bit CLA one nibble per cycle, LSB first.
// Optional build macro NIBBLE_SERIAL_SUB_EN adds a 'sub' input for a-b via inverted b and carry-in 1.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  // state  | meaning
  // IDLE   | waiting for start; sum/cout hold the last result
  // RUN    | one nibble per cycle through the CLA, idx selects the nibble
  // DONE   | one-cycle done pulse; start here begins the next op back-to-back

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic             accept;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (idx == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    cla_a   = 4'h0;
    cla_b   = 4'h0;
    cla_cin = 1'b0;
    case (state)
      S_RUN: begin
        busy    = 1'b1;
        cla_a   = a_reg[4*idx +: 4];
        cla_b   = b_reg[4*idx +: 4];
        cla_cin = carry_reg;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
`ifdef NIBBLE_SERIAL_SUB_EN
      // two's-complement subtract: invert b and force the initial carry
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
`else
      b_reg     <= b;
      carry_reg <= cin;
`endif
      idx <= '0;
    end else if (state == S_RUN) begin
      sum[4*idx +: 4] <= cla_sum;
      carry_reg       <= cla_cout;
      idx             <= idx + 1'b1;
      if (idx == LAST) cout <= cla_cout;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with a behavioural 4-bit CLA model.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        sub_i;
  logic        busy, done, cout;
  logic [15:0] sum;
  logic [3:0]  cla_a, cla_b, cla_sum;
  logic        cla_cin, cla_cout;

  int errors = 0;
  int checks = 0;
  logic [15:0] seq_a;
  logic [3:0]  seq_cin;

  always #5 clk = ~clk;

  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub(sub_i),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one op from a negedge; optionally pulse start mid-RUN with junk operands.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic ts, input logic [15:0] esum, input logic ecout,
                        input bit glitch, input string tag);
    int lat = 0;
    a = ta; b = tb_; cin = tc; sub_i = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub_i = 1'b0;
    seq_a = '0; seq_cin = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (glitch && n == 2) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
      if (glitch && n == 3) start = 1'b0;
      if (done) begin lat = n; break; end
      if (n <= 4) begin
        seq_a[4*(n-1) +: 4] = cla_a;
        seq_cin[n-1] = cla_cin;
        chk({tag, " busy"}, 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd5);
    chk({tag, " sum"}, 32'(sum), 32'(esum));
    chk({tag, " cout"}, 32'(cout), 32'(ecout));
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " sum hold"}, 32'(sum), 32'(esum));
  endtask

  logic [15:0] bb_a [4] = '{16'h0001, 16'h8000, 16'hABCD, 16'h7FFF};
  logic [15:0] bb_b [4] = '{16'h0002, 16'h8000, 16'h1111, 16'h0001};
  logic        bb_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] bb_s [4] = '{16'h0003, 16'h0000, 16'hBCDE, 16'h8001};
  logic        bb_o [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst sum", 32'(sum), 0);
    chk("rst cout", 32'(cout), 0);
    chk("rst cla", {23'd0, cla_a, cla_b, cla_cin}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, "op1");
    chk("op1 cla_a seq", 32'(seq_a), 32'h1234);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, "ripple");
    chk("ripple cla_cin seq", 32'(seq_cin), 32'hE);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 0, "cin");
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0, "noleak");
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1, "ignore");

    // back-to-back with start held high
    begin
      int cyc = 0, last = 0, k = 0;
      a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; start = 1'b1;
      @(posedge clk); #1;
      while (k < 4 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          chk("b2b sum", 32'(sum), 32'(bb_s[k]));
          chk("b2b cout", 32'(cout), 32'(bb_o[k]));
          chk("b2b interval", 32'(cyc - last), 32'd5);
          last = cyc;
          k++;
          if (k < 4) begin a = bb_a[k]; b = bb_b[k]; cin = bb_c[k]; end
          else start = 1'b0;
        end
      end
      start = 1'b0;
      chk("b2b count", 32'(k), 32'd4);
      @(negedge clk);
    end

    // reset during the second RUN cycle
    begin
      int seen = 0;
      a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; #1;
      chk("abort busy", 32'(busy), 0);
      chk("abort done", 32'(done), 0);
      chk("abort sum", 32'(sum), 0);
      chk("abort cout", 32'(cout), 0);
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 6; n++) begin @(negedge clk); if (done) seen++; end
      chk("abort no done", 32'(seen), 0);
      run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 0, "after abort");
    end

`ifdef NIBBLE_SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 0, "sub neg");
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0, "sub pos");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder controller. Slices WIDTH-bit operands into 4-bit nibbles and drives the external 4-bit carry-look-ahead adder one nibble per cycle, LSB first. It sits directly upstream and downstream of that adder: it feeds the adder's a/b/cin and consumes its sum/cout, with the carry chained through a register between cycles. It then assembles the full WIDTH-bit result and carry-out behind a start/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (NIB = WIDTH/4 nibble cycles per operation)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready (IDLE or DONE state)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  registered result; held until next accepted start completes
cout  output  1  registered final carry-out; held like sum
cla_a  output  4  nibble of A to the 4-bit CLA
cla_b  output  4  nibble of B to the 4-bit CLA
cla_cin  output  1  chained carry to the 4-bit CLA
cla_sum  input  4  CLA sum, combinational response to cla_a/cla_b/cla_cin
cla_cout  input  1  CLA carry-out

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; busy=0, done=0, sum=0, cout=0; operand regs, nibble index and carry reg cleared. cla_a/cla_b/cla_cin=0.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge -> latch a, b; carry_reg<=cin; idx<=0; go RUN.
- RUN:
  - cla_a = a_reg[4*idx+3:4*idx]; cla_b = b_reg nibble idx; cla_cin = carry_reg.
  - Each edge: sum[4*idx+3:4*idx]<=cla_sum; carry_reg<=cla_cout; idx<=idx+1.
  - When idx=NIB-1 at the edge: cout<=cla_cout; go DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 is accepted here exactly as in IDLE (back-to-back ops); else go IDLE.
- Outside RUN, cla_a/cla_b/cla_cin are driven 0.
- Latency: start accepted at edge k -> done high in the cycle after edge k+NIB (NIB+1 cycles start-to-done). Throughput: one op per NIB+1 cycles.
- Width rules:
  - idx is clog2(NIB) bits (minimum 1).
  - The carry register is 1 bit.
  - No overflow flag; cout is the unsigned carry.
- start while busy=1: ignored. Operands and result are unaffected.
- a/b/cin changing after acceptance: no effect (latched copies are used).
- sum bits are updated nibble by nibble during RUN. Downstream logic may rely on sum/cout only when done=1 or in the IDLE state that follows.
- Reset mid-RUN: immediate abort; all outputs return to reset values; no done pulse.
- WIDTH=4: single RUN cycle; same rules apply.

Optional Feature:
NIBBLE_SERIAL_SUB_EN
- Defined: adds input port sub (1 bit), captured with start.
  - sub=1: b_reg<=~b and carry_reg<=1, with cin ignored. The result is a-b; cout=1 means no borrow.
  - sub=0: identical to the undefined build.
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start 1 cycle -> busy high 4 cycles; cla_a sequence 4,3,2,1; done pulse 5 cycles after start edge; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples every nibble (cla_cin=0,1,1,1); sum=0x0000, cout=1.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Then a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0 (the previous carry does not leak).
- Hold start=1 continuously with a new operand pair each time done=1 -> back-to-back ops every 5 cycles, all results correct. A start pulse with different operands mid-RUN -> ignored, and the result matches the first operands.
- Assert rst during the 2nd RUN cycle -> busy, done, sum, cout drop to 0 immediately; no done pulse; the next op completes normally.
- (NIBBLE_SERIAL_SUB_EN) a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
